// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller shared by icache line refills and load/store traffic.
// Round-robin arbitration, IO write back-pressure, flush abort of in-flight reads.
module mem_ctrl #(
    parameter int unsigned LINE_BYTES = 64,
    parameter logic [1:0]  IO_ADDR_HI = 2'b11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rob_clear,
    input  logic                    if_en,
    input  logic [31:0]             if_pc,
    output logic                    if_done,
    output logic [8*LINE_BYTES-1:0] if_data,
    input  logic                    lsb_en,
    input  logic                    lsb_wr,
    input  logic [1:0]              lsb_size,
    input  logic [31:0]             lsb_addr,
    input  logic [31:0]             lsb_wdata,
    output logic [31:0]             lsb_rdata,
    output logic                    lsb_done,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full
);
    localparam int unsigned IW = $clog2(LINE_BYTES);
    localparam int unsigned CW = IW + 1;

    typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;

    state_t        state, state_next;
    logic [31:0]   base;
    logic [31:0]   wdata;
    logic [CW-1:0] n_bytes;
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] capture_cnt;
    logic          rr_if_next;
    logic          resume;

    logic          if_ok, ls_ok;
    logic          grant_if, grant_ls;
    logic [CW-1:0] size_bytes;
    logic [31:0]   wr_addr;
    logic          wr_hold;
    logic          last_capture;
    logic [IW-1:0] cap_idx;

    assign if_ok        = if_en && !rob_clear;
    assign ls_ok        = lsb_en && (lsb_wr || !rob_clear);
    assign wr_addr      = base + 32'(issue_cnt);
    assign wr_hold      = (wr_addr[17:16] == IO_ADDR_HI) && io_buffer_full;
    assign last_capture = (capture_cnt == n_bytes - CW'(1));
    assign cap_idx      = capture_cnt[IW-1:0];

    always_comb begin
        case (lsb_size)
            2'd0:    size_bytes = CW'(1);
            2'd1:    size_bytes = CW'(2);
            default: size_bytes = CW'(4);
        endcase
    end

    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_ls   = 1'b0;
        if (rdy) begin
            case (state)
                IDLE: begin
                    if (if_ok && ls_ok) begin
                        grant_if = rr_if_next;
                        grant_ls = !rr_if_next;
                    end else begin
                        grant_if = if_ok;
                        grant_ls = ls_ok;
                    end
                    if (grant_if)
                        state_next = IF_RD;
                    else if (grant_ls)
                        state_next = lsb_wr ? LS_WR : LS_RD;
                end
                IF_RD, LS_RD: begin
                    if (rob_clear)
                        state_next = IDLE;
                    else if (!resume && last_capture)
                        state_next = DONE;
                end
                LS_WR:   if (issue_cnt == n_bytes) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            if_done     <= 1'b0;
            lsb_done    <= 1'b0;
            mem_wr      <= 1'b0;
            mem_a       <= '0;
            mem_dout    <= '0;
            if_data     <= '0;
            lsb_rdata   <= '0;
            rr_if_next  <= 1'b0;
            base        <= '0;
            wdata       <= '0;
            n_bytes     <= '0;
            issue_cnt   <= '0;
            capture_cnt <= '0;
            resume      <= 1'b0;
        end else if (!rdy) begin
            // The byte on mem_din during a stall is not trusted; re-issue on resume.
            mem_wr <= 1'b0;
            if (state == IF_RD || state == LS_RD)
                resume <= 1'b1;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        base        <= if_pc;
                        n_bytes     <= CW'(LINE_BYTES);
                        mem_a       <= if_pc;
                        issue_cnt   <= CW'(1);
                        capture_cnt <= '0;
                        resume      <= 1'b0;
                        rr_if_next  <= 1'b0;
                    end else if (grant_ls) begin
                        base        <= lsb_addr;
                        n_bytes     <= size_bytes;
                        wdata       <= lsb_wdata;
                        mem_a       <= lsb_addr;
                        // Stores count bytes written, so they start from zero.
                        issue_cnt   <= lsb_wr ? '0 : CW'(1);
                        capture_cnt <= '0;
                        resume      <= 1'b0;
                        rr_if_next  <= 1'b1;
                        if (!lsb_wr)
                            lsb_rdata <= '0;
                    end
                end
                IF_RD, LS_RD: begin
                    if (!rob_clear) begin
                        if (resume) begin
                            resume    <= 1'b0;
                            mem_a     <= base + 32'(capture_cnt);
                            issue_cnt <= capture_cnt + CW'(1);
                        end else begin
                            if (state == IF_RD)
                                if_data[{cap_idx, 3'b000} +: 8] <= mem_din;
                            else
                                lsb_rdata[{capture_cnt[1:0], 3'b000} +: 8] <= mem_din;
                            if (last_capture) begin
                                if (state == IF_RD)
                                    if_done <= 1'b1;
                                else
                                    lsb_done <= 1'b1;
                            end else begin
                                capture_cnt <= capture_cnt + CW'(1);
                                if (issue_cnt < n_bytes) begin
                                    mem_a     <= base + 32'(issue_cnt);
                                    issue_cnt <= issue_cnt + CW'(1);
                                end
                            end
                        end
                    end
                end
                LS_WR: begin
                    if (issue_cnt == n_bytes) begin
                        lsb_done <= 1'b1;
                        mem_wr   <= 1'b0;
                    end else if (wr_hold) begin
                        mem_wr <= 1'b0;
                    end else begin
                        mem_a     <= wr_addr;
                        mem_dout  <= wdata[{issue_cnt[1:0], 3'b000} +: 8];
                        mem_wr    <= 1'b1;
                        issue_cnt <= issue_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if_done  <= 1'b0;
                    lsb_done <= 1'b0;
                    mem_wr   <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: RAM model, scoreboard queues, vector table
// for loads/stores, and hand sequences for arbitration, IO stall, flush, stall and reset.
module tb_mem_ctrl;
    localparam int unsigned LB = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            rdy = 1'b1;
    logic            rob_clear = 1'b0;
    logic            if_en = 1'b0;
    logic [31:0]     if_pc = '0;
    logic            if_done;
    logic [8*LB-1:0] if_data;
    logic            lsb_en = 1'b0;
    logic            lsb_wr = 1'b0;
    logic [1:0]      lsb_size = '0;
    logic [31:0]     lsb_addr = '0;
    logic [31:0]     lsb_wdata = '0;
    logic [31:0]     lsb_rdata;
    logic            lsb_done;
    logic [7:0]      mem_din;
    logic [7:0]      mem_dout;
    logic [31:0]     mem_a;
    logic            mem_wr;
    logic            io_buffer_full = 1'b0;

    logic [7:0] ram [0:131071];

    mem_ctrl #(.LINE_BYTES(LB), .IO_ADDR_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
        .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_rdata(lsb_rdata), .lsb_done(lsb_done),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    assign mem_din = ram[mem_a[16:0]];
    always #5 clk = ~clk;

    typedef struct { bit is_load; logic [31:0] data; } ls_exp_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; } wr_exp_t;
    typedef struct {
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    ls_exp_t         exp_ls[$];
    wr_exp_t         exp_wr[$];
    logic [8*LB-1:0] exp_if[$];
    vec_t            vecs[12];
    ls_exp_t         mon_ls;
    wr_exp_t         mon_wr;
    logic [8*LB-1:0] mon_if;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event with empty scoreboard", name);
    endtask

    function automatic logic [8*LB-1:0] line_at(input logic [31:0] pc);
        logic [8*LB-1:0] l;
        for (int unsigned i = 0; i < LB; i++)
            l[8*i +: 8] = ram[pc[16:0] + 17'(i)];
        return l;
    endfunction

    // Scoreboard consumer: every DUT output event pops its expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_wr) begin
                if (exp_wr.size() == 0) flag_unexpected("write");
                else begin
                    mon_wr = exp_wr.pop_front();
                    check("write_addr", mem_a, mon_wr.addr);
                    check("write_data", mem_dout, mon_wr.data);
                end
                ram[mem_a[16:0]] = mem_dout;
            end
            if (lsb_done) begin
                if (exp_ls.size() == 0) flag_unexpected("lsb_done");
                else begin
                    mon_ls = exp_ls.pop_front();
                    if (mon_ls.is_load) check("load_data", lsb_rdata, mon_ls.data);
                end
            end
            if (if_done) begin
                if (exp_if.size() == 0) flag_unexpected("if_done");
                else begin
                    mon_if = exp_if.pop_front();
                    check("fetch_line", if_data, mon_if);
                end
            end
        end
    end

    task automatic do_ls(input string name, input bit wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
        int unsigned n;
        int unsigned lat;
        ls_exp_t     e;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        e.is_load = !wr;
        e.data    = rdata;
        exp_ls.push_back(e);
        if (wr) begin
            for (int unsigned i = 0; i < n; i++) begin
                wr_exp_t w;
                w.addr = addr + 32'(i);
                w.data = wdata[8*i +: 8];
                exp_wr.push_back(w);
            end
        end
        lsb_en = 1'b1; lsb_wr = wr; lsb_size = size; lsb_addr = addr; lsb_wdata = wdata;
        lat = 0;
        for (int unsigned i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (lsb_done) begin lat = i; break; end
        end
        lsb_en = 1'b0;
        check({name, "_latency"}, lat, wr ? n + 2 : n + 1);
        @(negedge clk);
    endtask

    task automatic do_fetch(input logic [31:0] pc);
        int unsigned lat;
        exp_if.push_back(line_at(pc));
        if_en = 1'b1; if_pc = pc;
        lat = 0;
        for (int unsigned i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (if_done) begin lat = i; break; end
        end
        if_en = 1'b0;
        check("fetch_latency", lat, LB + 1);
        @(negedge clk);
    endtask

    // Both requesters raised together; order encoded as digits, 1 = LSB, 2 = fetch.
    task automatic arb_round(output int unsigned order);
        ls_exp_t e;
        e.is_load = 1'b1;
        e.data    = 32'h0000_0011;
        exp_ls.push_back(e);
        exp_if.push_back(line_at(32'h40));
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h100;
        if_en = 1'b1; if_pc = 32'h40;
        order = 0;
        for (int i = 0; i < 200 && (lsb_en || if_en); i++) begin
            @(negedge clk);
            if (lsb_done) begin order = order * 10 + 1; lsb_en = 1'b0; end
            if (if_done)  begin order = order * 10 + 2; if_en = 1'b0; end
        end
        lsb_en = 1'b0; if_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        int unsigned o1, o2, lat, stall, cnt;
        bit          started;

        vecs[0]  = '{1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'h4433_2211};
        vecs[1]  = '{1'b0, 2'd0, 32'h0000_0100, 32'h0, 32'h0000_0011};
        vecs[2]  = '{1'b0, 2'd1, 32'h0000_0101, 32'h0, 32'h0000_3322};
        vecs[3]  = '{1'b0, 2'd3, 32'h0000_0101, 32'h0, 32'h5544_3322};
        vecs[4]  = '{1'b1, 2'd0, 32'h0000_0200, 32'h0000_00A5, 32'h0};
        vecs[5]  = '{1'b0, 2'd2, 32'h0000_0200, 32'h0, 32'h0000_00A5};
        vecs[6]  = '{1'b1, 2'd1, 32'h0000_0202, 32'hFFFF_1234, 32'h0};
        vecs[7]  = '{1'b0, 2'd2, 32'h0000_0200, 32'h0, 32'h1234_00A5};
        vecs[8]  = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0BAD_F00D, 32'h0};
        vecs[9]  = '{1'b0, 2'd2, 32'h0000_0000, 32'h0, 32'h000B_ADF0};
        vecs[10] = '{1'b0, 2'd0, 32'h0001_FFFF, 32'h0, 32'h0000_000D};
        vecs[11] = '{1'b0, 2'd2, 32'h0000_0040, 32'h0, 32'h0302_0100};

        for (int unsigned i = 0; i < 131072; i++) ram[i] = 8'h00;
        for (int unsigned i = 0; i < LB; i++) ram[17'h40 + 17'(i)] = 8'(i);
        ram[17'h100] = 8'h11; ram[17'h101] = 8'h22; ram[17'h102] = 8'h33;
        ram[17'h103] = 8'h44; ram[17'h104] = 8'h55;

        repeat (2) @(negedge clk);
        check("rst_if_done", if_done, 1'b0);
        check("rst_lsb_done", lsb_done, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_dout", mem_dout, 8'h0);
        check("rst_if_data", if_data, '0);
        check("rst_lsb_rdata", lsb_rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        do_fetch(32'h40);

        arb_round(o1);
        arb_round(o2);
        check("arb_order", o1 * 100 + o2, 1212);

        for (int unsigned k = 0; k < 12; k++)
            do_ls($sformatf("vec%0d", k), vecs[k].wr, vecs[k].size, vecs[k].addr,
                  vecs[k].wdata, vecs[k].rdata);

        // IO store held off for three cycles on byte 1.
        exp_ls.push_back('{1'b0, 32'h0});
        exp_wr.push_back('{32'h0003_0000, 8'hEF});
        exp_wr.push_back('{32'h0003_0001, 8'hBE});
        exp_wr.push_back('{32'h0003_0002, 8'hAD});
        exp_wr.push_back('{32'h0003_0003, 8'hDE});
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2;
        lsb_addr = 32'h0003_0000; lsb_wdata = 32'hDEAD_BEEF;
        lat = 0; stall = 0; started = 1'b0;
        for (int unsigned i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (stall > 0) begin
                check("io_stall_no_write", mem_wr, 1'b0);
                stall--;
                if (stall == 0) io_buffer_full = 1'b0;
            end
            if (mem_wr && !started) begin started = 1'b1; io_buffer_full = 1'b1; stall = 3; end
            if (lsb_done) begin lat = i; break; end
        end
        lsb_en = 1'b0; io_buffer_full = 1'b0;
        check("io_store_latency", lat, 9);
        check("io_store_all_written", exp_wr.size(), 0);
        @(negedge clk);

        // Flush on the 10th edge of a refill.
        if_en = 1'b1; if_pc = 32'h40;
        repeat (10) @(negedge clk);
        rob_clear = 1'b1; if_en = 1'b0;
        @(negedge clk);
        rob_clear = 1'b0;
        check("flush_mem_a_held", mem_a, 32'h49);
        do_ls("post_flush_load", 1'b0, 2'd0, 32'h104, 32'h0, 32'h0000_0055);
        cnt = 0;
        repeat (70) begin @(negedge clk); if (if_done) cnt++; end
        check("flush_no_if_done", cnt, 0);

        // rdy low for two cycles mid-load.
        exp_ls.push_back('{1'b1, 32'h4433_2211});
        lsb_en = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h100;
        repeat (2) @(negedge clk);
        rdy = 1'b0;
        repeat (2) @(negedge clk);
        rdy = 1'b1;
        cnt = 0;
        for (int unsigned i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (lsb_done) begin cnt = 1; break; end
        end
        lsb_en = 1'b0;
        check("stall_load_done", cnt, 1);
        @(negedge clk);

        // Asynchronous reset in the middle of a store.
        exp_wr.push_back('{32'h0000_0300, 8'h0D});
        lsb_en = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2;
        lsb_addr = 32'h300; lsb_wdata = 32'hCAFE_F00D;
        cnt = 0;
        for (int unsigned i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (mem_wr) begin cnt = 1; break; end
        end
        check("rst_mid_write_started", cnt, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_mem_wr", mem_wr, 1'b0);
        check("rst_async_mem_a", mem_a, 32'h0);
        check("rst_async_mem_dout", mem_dout, 8'h0);
        check("rst_async_if_data", if_data, '0);
        check("rst_async_lsb_rdata", lsb_rdata, 32'h0);
        lsb_en = 1'b0;
        exp_wr.delete();
        repeat (2) @(negedge clk);
        check("rst_held_lsb_done", lsb_done, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        arb_round(o1);
        check("rst_arb_lsb_first", o1, 12);

        check("drain_ls", exp_ls.size(), 0);
        check("drain_if", exp_if.size(), 0);
        check("drain_wr", exp_wr.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
